// File: rtl/fifo_types.sv
// Shared types for the parametrised instruction-queue FIFO.
package fifo_types;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ERR_NONE             = 2'd0,
    FLUSH_DOES_NOT_EMPTY = 2'd1,
    OVERFLOW_ACCEPTED    = 2'd2,
    COUNT_MISMATCH       = 2'd3
  } error_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
interface fifo_sync_param_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             ack_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             yumi_i;
  logic [CNT_W-1:0] count_o;
  logic             almost_full_o;

  modport slave (
    input  valid_i, data_i, yumi_i,
    output ready_o, ack_o, valid_o, data_o, count_o, almost_full_o
  );

  modport master (
    output valid_i, data_i, yumi_i,
    input  ready_o, ack_o, valid_o, data_o, count_o, almost_full_o
  );
endinterface

// File: rtl/fifo_sync_param_wrap_ptr.sv
// Circular pointer register that wraps explicitly at DEPTH-1 (non power-of-two safe).
module fifo_wrap_ptr
  import fifo_types::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             adv_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (adv_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost-full flag and synchronous flush.
module fifo_sync_param
  import fifo_types::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_i,
  fifo_sync_param_if.slave    bus
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [WIDTH-1:0] entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_d, count_q;
  logic             ack_d, ack_q;
  logic             flush_q;
  logic             ready_c, valid_c, enq_c, deq_c;

  // Handshake flags depend on the registered count only.
  assign ready_c = (count_q != CNT_W'(DEPTH));
  assign valid_c = (count_q != '0);
  assign enq_c   = bus.valid_i & ready_c & ~flush_i;
  assign deq_c   = bus.yumi_i  & valid_c & ~flush_i;

  always_comb begin
    count_d = count_q;
    ack_d   = 1'b0;
    if (flush_i) begin
      count_d = '0;
    end else begin
      ack_d = enq_c;
      if (enq_c && !deq_c)      count_d = count_q + CNT_W'(1);
      else if (!enq_c && deq_c) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ack_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ack_q   <= ack_d;
      flush_q <= flush_i;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (enq_c) mem_q[wr_ptr] <= bus.data_i;
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (flush_i),
    .adv_i   (enq_c),
    .ptr_o   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (flush_i),
    .adv_i   (deq_c),
    .ptr_o   (rd_ptr)
  );

  assign bus.ready_o       = ready_c;
  assign bus.valid_o       = valid_c;
  assign bus.ack_o         = ack_q;
  assign bus.count_o       = count_q;
  assign bus.almost_full_o = (count_q >= CNT_W'(AF_THRESH));
  assign bus.data_o        = mem_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.yumi_i && !valid_c))
        else $warning("fifo_sync_param: yumi_i on empty FIFO ignored");
      assert (count_q <= CNT_W'(DEPTH))
        else $error("fifo_sync_param: error %0d", COUNT_MISMATCH);
      assert (!(enq_c && !ready_c))
        else $error("fifo_sync_param: error %0d", OVERFLOW_ACCEPTED);
      assert (!flush_q || count_q == '0)
        else $error("fifo_sync_param: error %0d", FLUSH_DOES_NOT_EMPTY);
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param at DEPTH=8 (instance a) and DEPTH=5 (instance b).
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic reset_n;
  logic flush_a, flush_b;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(32), .DEPTH(8)) ia ();
  fifo_sync_param_if #(.WIDTH(32), .DEPTH(5)) ib ();

  fifo_sync_param #(.WIDTH(32), .DEPTH(8)) u_a (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_a), .bus(ia)
  );
  fifo_sync_param #(.WIDTH(32), .DEPTH(5)) u_b (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_b), .bus(ib)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          ma = 0;
  int          mb = 0;
  logic [31:0] qa [$];
  logic [31:0] qb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] cnt, input logic rdy,
                           input logic vld, input logic af, input logic ack,
                           input int m, input int depth, input int thr, input logic exp_ack);
    chk({tag, "_count"}, cnt, 32'(m));
    chk({tag, "_ready"}, 32'(rdy), 32'(m != depth));
    chk({tag, "_valid"}, 32'(vld), 32'(m != 0));
    chk({tag, "_afull"}, 32'(af), 32'(m >= thr));
    chk({tag, "_ack"},   32'(ack), 32'(exp_ack));
  endtask

  task automatic tick_a(input logic v, input logic [31:0] d, input logic y, input logic f);
    logic e_enq, e_deq;
    ia.valid_i = v; ia.data_i = d; ia.yumi_i = y; flush_a = f;
    e_enq = !f && v && (ma < 8);
    e_deq = !f && y && (ma > 0);
    @(posedge clk); #1;
    if (f) begin
      ma = 0;
      qa.delete();
    end else begin
      if (e_enq) qa.push_back(d);
      ma = ma + int'(e_enq) - int'(e_deq);
    end
    chk_state("a", 32'(ia.count_o), ia.ready_o, ia.valid_o, ia.almost_full_o, ia.ack_o,
              ma, 8, 7, e_enq);
  endtask

  task automatic tick_b(input logic v, input logic [31:0] d, input logic y);
    logic e_enq, e_deq;
    ib.valid_i = v; ib.data_i = d; ib.yumi_i = y; flush_b = 1'b0;
    e_enq = v && (mb < 5);
    e_deq = y && (mb > 0);
    @(posedge clk); #1;
    if (e_enq) qb.push_back(d);
    mb = mb + int'(e_enq) - int'(e_deq);
    chk_state("b", 32'(ib.count_o), ib.ready_o, ib.valid_o, ib.almost_full_o, ib.ack_o,
              mb, 5, 4, e_enq);
  endtask

  // Monitor: every dequeue handshake must present the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ia.valid_o && ia.yumi_i && !flush_a) begin
        if (qa.size() == 0) chk("a_pop_unexpected", 32'd1, 32'd0);
        else chk("a_data", ia.data_o, qa.pop_front());
      end
      if (ib.valid_o && ib.yumi_i && !flush_b) begin
        if (qb.size() == 0) chk("b_pop_unexpected", 32'd1, 32'd0);
        else chk("b_data", ib.data_o, qb.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
    ia.valid_i = 1'b0; ia.data_i = '0; ia.yumi_i = 1'b0;
    ib.valid_i = 1'b0; ib.data_i = '0; ib.yumi_i = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk_state("rst_a", 32'(ia.count_o), ia.ready_o, ia.valid_o, ia.almost_full_o, ia.ack_o,
              0, 8, 7, 1'b0);
    chk_state("rst_b", 32'(ib.count_o), ib.ready_o, ib.valid_o, ib.almost_full_o, ib.ack_o,
              0, 5, 4, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill DEPTH=8, overflow push, drain
    for (int i = 1; i <= 8; i++) tick_a(1'b1, 32'(i), 1'b0, 1'b0);
    tick_a(1'b1, 32'h9, 1'b0, 1'b0);
    tick_a(1'b1, 32'h9, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick_a(1'b0, '0, 1'b1, 1'b0);

    // Wrap on DEPTH=5
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) tick_b(1'b1, 32'(16 * (r + 1) + i), 1'b0);
      for (int i = 0; i < 3; i++) tick_b(1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 5; i++) tick_b(1'b1, 32'(32'hA + i), 1'b0);
    tick_b(1'b1, 32'h99, 1'b0);
    for (int i = 0; i < 5; i++) tick_b(1'b0, '0, 1'b1);

    // Simultaneous push/pop at count 4
    for (int i = 0; i < 4; i++) tick_a(1'b1, 32'(32'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick_a(1'b1, 32'(32'h20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick_a(1'b0, '0, 1'b1, 1'b0);

    // Flush at count 6 with concurrent push and pop
    for (int i = 0; i < 6; i++) tick_a(1'b1, 32'(32'h40 + i), 1'b0, 1'b0);
    tick_a(1'b1, 32'hF, 1'b1, 1'b1);
    tick_a(1'b0, '0, 1'b1, 1'b0);
    tick_a(1'b1, 32'h55, 1'b0, 1'b0);
    tick_a(1'b1, 32'h56, 1'b1, 1'b0);
    tick_a(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with count 3
    for (int i = 0; i < 3; i++) tick_a(1'b1, 32'(32'h60 + i), 1'b0, 1'b0);
    ia.valid_i = 1'b0; ia.yumi_i = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    ma = 0;
    qa.delete();
    chk_state("arst_a", 32'(ia.count_o), ia.ready_o, ia.valid_o, ia.almost_full_o, ia.ack_o,
              0, 8, 7, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick_a(1'b0, '0, 1'b1, 1'b0);
    tick_a(1'b1, 32'h77, 1'b0, 1'b0);
    tick_a(1'b0, '0, 1'b1, 1'b0);

    tick_a(1'b0, '0, 1'b0, 1'b0);
    chk("a_leftover", 32'(qa.size()), 32'd0);
    chk("b_leftover", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
